addsub_sequencer: RTL

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/addsub_pkg.sv
// Shared types and command-byte field positions for the add/subtract sequencer.
package addsub_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_A,
        S_B,
        S_EXEC,
        S_OUT
    } state_e;

    localparam int unsigned CMD_SUB_BIT   = 0;
    localparam int unsigned CMD_CHAIN_BIT = 1;

endpackage

// File: rtl/addsub_sequencer.sv
// Turns a command/operand byte stream into operations on an external adder/subtractor,
// registers the result with zero/negative flags and keeps it as an accumulator for chaining.
module addsub_sequencer
    import addsub_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_sub,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                op_sub_q, op_sub_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_zero_q, out_zero_d;
    logic                out_neg_q, out_neg_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                in_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CMD;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sub_q   <= 1'b0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_neg_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_sub_q   <= op_sub_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            out_neg_q  <= out_neg_d;
            acc_q      <= acc_d;
        end
    end

    // Ready is held low during reset so no byte is ever seen as accepted then.
    assign in_ready = !rst && (state_q == S_CMD || state_q == S_A || state_q == S_B);
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_sub_d   = op_sub_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        out_neg_d  = out_neg_q;
        acc_d      = acc_q;
        unique case (state_q)
            S_CMD: begin
                if (in_xfer) begin
                    op_sub_d = in_data[CMD_SUB_BIT];
                    if (in_data[CMD_CHAIN_BIT]) begin
                        op_a_d  = acc_q;
                        state_d = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
            end
            S_A: begin
                if (in_xfer) begin
                    op_a_d  = in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (in_xfer) begin
                    op_b_d  = in_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                out_data_d = alu_result;
                out_zero_d = (alu_result == '0);
                out_neg_d  = alu_result[DATA_W-1];
                acc_d      = alu_result;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_CMD;
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_sub    = op_sub_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_neg   = out_neg_q;
    assign out_valid = (state_q == S_OUT);

endmodule
